vga_fb_fill_ctrl: RTL

Write-port controller for the 80x60 VGA framebuffer. It shares the single framebuffer write port between CPU MMIO pixel writes and a hardware rectangle-fill engine, so firmware can clear the screen or draw blocks in one MMIO command instead of thousands of stores. It sits between the IOBUS decode logic and `vga_fb_driver_80x60`, and drives that driver's WA/WD/WE directly.

---
 rtl/vga_fb_pkg.sv | 21 ++
 rtl/fb_rect_cursor.sv | 57 +++++
 rtl/vga_fb_fill_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/vga_fb_pkg.sv
// Shared constants, FSM state type and address packing for the 80x60 framebuffer write port.
// Contents: H_PIX, V_PIX, ADDR_W, fb_state_t {IDLE, FILL, DONE}, fb_addr(x, y) -> {y, x}.
// No logic of its own; latency and backpressure belong to the modules that import it.
package vga_fb_pkg;

  localparam int H_PIX  = 80;
  localparam int V_PIX  = 60;
  localparam int ADDR_W = 13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fb_state_t;

  // Framebuffer address is row-major with a 128-wide row stride: {y[5:0], x[6:0]}.
  function automatic logic [ADDR_W-1:0] fb_addr(input logic [6:0] x, input logic [5:0] y);
    return {y, x};
  endfunction

endpackage

// File: rtl/fb_rect_cursor.sv
// Raster cursor for the fill engine: walks (x, y) over an inclusive rectangle in row-major order.
// Latency: load/advance take effect on the next CLK edge; o_last is combinational from the registers.
// Backpressure: the cursor only moves when i_advance is high, so the owner stalls it by holding advance low.
// Ports: CLK/RST (sync, active high); i_load with i_x0/i_x1/i_y0/i_y1 captures bounds and
//        parks the cursor at (x0, y0); i_advance steps one pixel; o_x/o_y current pixel;
//        o_last high when the cursor sits on (x1, y1).
module fb_rect_cursor (
  input  logic       CLK,
  input  logic       RST,
  input  logic       i_load,
  input  logic       i_advance,
  input  logic [6:0] i_x0,
  input  logic [6:0] i_x1,
  input  logic [5:0] i_y0,
  input  logic [5:0] i_y1,
  output logic [6:0] o_x,
  output logic [5:0] o_y,
  output logic       o_last
);

  logic [6:0] r_x0;
  logic [6:0] r_x1;
  logic [5:0] r_y1;
  logic [6:0] r_x;
  logic [5:0] r_y;
  logic       w_row_end;

  // y0 is only needed at load time: rows never restart, they only advance.
  assign w_row_end = (r_x == r_x1);
  assign o_last    = w_row_end && (r_y == r_y1);
  assign o_x       = r_x;
  assign o_y       = r_y;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_x0 <= '0;
      r_x1 <= '0;
      r_y1 <= '0;
      r_x  <= '0;
      r_y  <= '0;
    end else if (i_load) begin
      r_x0 <= i_x0;
      r_x1 <= i_x1;
      r_y1 <= i_y1;
      r_x  <= i_x0;
      r_y  <= i_y0;
    end else if (i_advance) begin
      if (w_row_end) begin
        r_x <= r_x0;
        r_y <= r_y + 6'd1;
      end else begin
        r_x <= r_x + 7'd1;
      end
    end
  end

endmodule

// File: rtl/vga_fb_fill_ctrl.sv
// Framebuffer write-port arbiter: CPU pixel writes (fixed priority) plus a rectangle-fill engine.
// Latency: CPU write appears on fb_we one cycle after cpu_wr_req; first fill pixel two cycles after fill_start.
// Backpressure: a CPU write steals the fill's slot and the cursor holds, so each collision adds one cycle.
// Ports: CLK/RST (sync, active high); cpu_wr_req/cpu_wa/cpu_wd single-pixel writes (cpu_wa also
//        steers the read address while idle); fill_start + fill_x0/x1/y0/y1/fill_color launch a fill;
//        busy/done status; fb_wa/fb_wd/fb_we registered drive to the framebuffer driver.
module vga_fb_fill_ctrl
  import vga_fb_pkg::*;
#(
  parameter int H_PIX  = vga_fb_pkg::H_PIX,
  parameter int V_PIX  = vga_fb_pkg::V_PIX,
  parameter int ADDR_W = vga_fb_pkg::ADDR_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cpu_wr_req,
  input  logic [ADDR_W-1:0] cpu_wa,
  input  logic [7:0]        cpu_wd,
  input  logic              fill_start,
  input  logic [6:0]        fill_x0,
  input  logic [6:0]        fill_x1,
  input  logic [5:0]        fill_y0,
  input  logic [5:0]        fill_y1,
  input  logic [7:0]        fill_color,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] fb_wa,
  output logic [7:0]        fb_wd,
  output logic              fb_we
);

  localparam logic [6:0] X_MAX = 7'(H_PIX - 1);
  localparam logic [5:0] Y_MAX = 6'(V_PIX - 1);

  fb_state_t  r_state;
  logic [7:0] r_color;

  logic [6:0] w_x0, w_x1, w_cur_x;
  logic [5:0] w_y0, w_y1, w_cur_y;
  logic       w_empty;
  logic       w_cur_last;
  logic       w_load;
  logic       w_advance;

  // Clamp to the visible area first; an inverted rectangle after clamping is an empty fill.
  assign w_x0    = (fill_x0 > X_MAX) ? X_MAX : fill_x0;
  assign w_x1    = (fill_x1 > X_MAX) ? X_MAX : fill_x1;
  assign w_y0    = (fill_y0 > Y_MAX) ? Y_MAX : fill_y0;
  assign w_y1    = (fill_y1 > Y_MAX) ? Y_MAX : fill_y1;
  assign w_empty = (w_x0 > w_x1) || (w_y0 > w_y1);

  assign w_load    = (r_state == IDLE) && fill_start;
  // The cursor moves only on cycles where the fill actually owns the write port.
  assign w_advance = (r_state == FILL) && !cpu_wr_req;

  fb_rect_cursor u_cursor (
    .CLK       (CLK),
    .RST       (RST),
    .i_load    (w_load),
    .i_advance (w_advance),
    .i_x0      (w_x0),
    .i_x1      (w_x1),
    .i_y0      (w_y0),
    .i_y1      (w_y1),
    .o_x       (w_cur_x),
    .o_y       (w_cur_y),
    .o_last    (w_cur_last)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_color <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      fb_we   <= 1'b0;
      fb_wa   <= '0;
      fb_wd   <= '0;
    end else begin
      done  <= 1'b0;
      fb_we <= 1'b0;

      // CPU owns the port whenever it asks, in any state.
      if (cpu_wr_req) begin
        fb_we <= 1'b1;
        fb_wa <= cpu_wa;
        fb_wd <= cpu_wd;
      end

      case (r_state)
        IDLE: begin
          // Idle port follows the CPU address so the driver's read path serves MMIO reads.
          if (!cpu_wr_req) fb_wa <= cpu_wa;
          if (fill_start) begin
            r_color <= fill_color;
            busy    <= 1'b1;
            r_state <= w_empty ? DONE : FILL;
          end
        end
        FILL: begin
          if (!cpu_wr_req) begin
            fb_we <= 1'b1;
            fb_wa <= fb_addr(w_cur_x, w_cur_y);
            fb_wd <= r_color;
            if (w_cur_last) r_state <= DONE;
          end
        end
        DONE: begin
          // busy drops and done pulses together, one cycle after the last pixel.
          if (!cpu_wr_req) fb_wa <= cpu_wa;
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
